// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_if
//  Description : Handshake and memory-control bundle for the mem_access stage.
//                slave  = the stage itself, master = its environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_access_if;
  logic lr;            // request from ALU stage (asynchronous)
  logic la;            // acknowledge to ALU stage
  logic rr;            // request to writeback stage
  logic ra;            // acknowledge from writeback stage (asynchronous)
  logic isLoad;        // bundled data, stable while lr=1
  logic isStore;       // bundled data, stable while lr=1
  logic memAck;        // memory done (asynchronous level)
  logic memAddrLatch;  // one-cycle address capture pulse
  logic memReadEn;     // read strobe
  logic memWriteEn;    // write strobe
  logic memDataLatch;  // one-cycle read-data capture pulse
  logic memErr;        // sticky error flag

  modport slave (
    input  lr, ra, isLoad, isStore, memAck,
    output la, rr, memAddrLatch, memReadEn, memWriteEn, memDataLatch, memErr
  );

  modport master (
    output lr, ra, isLoad, isStore, memAck,
    input  la, rr, memAddrLatch, memReadEn, memWriteEn, memDataLatch, memErr
  );
endinterface
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access
//  Description : miniMIPS memory-access stage. Takes the ALU token on a 4-phase
//                lr/la handshake, sequences address latch / strobe / data latch
//                for loads and stores, and hands the token to writeback on a
//                4-phase rr/ra handshake. All outputs come straight from flops.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access #(
  parameter int SYNC_STAGES = 2,   // synchronizer depth on lr, ra, memAck (2..3)
  parameter int MEM_TIMEOUT = 15   // ACCESS cycles tolerated before abort (>=1)
) (
  input  wire logic     clk,
  input  wire logic     _rst,      // asynchronous, active-low
  mem_access_if.slave   bus
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_ACCESS = 3'd2,
    S_DATA   = 3'd3,
    S_REQ    = 3'd4,
    S_RTZ    = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   is_load_q, is_load_d;
  logic [SYNC_STAGES-1:0] lr_sync_q, lr_sync_d;
  logic [SYNC_STAGES-1:0] ra_sync_q, ra_sync_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic                   la_q, la_d;
  logic                   rr_q, rr_d;
  logic                   addr_latch_q, addr_latch_d;
  logic                   read_en_q, read_en_d;
  logic                   write_en_q, write_en_d;
  logic                   data_latch_q, data_latch_d;
  logic                   err_q, err_d;

  logic lr_s, ra_s, ack_s;

  assign lr_s  = lr_sync_q[SYNC_STAGES-1];
  assign ra_s  = ra_sync_q[SYNC_STAGES-1];
  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  // Next-state, counter, error and registered-output decode for the token sequencer.
  always_comb begin
    lr_sync_d  = {lr_sync_q[SYNC_STAGES-2:0], bus.lr};
    ra_sync_d  = {ra_sync_q[SYNC_STAGES-2:0], bus.ra};
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], bus.memAck};

    state_d   = state_q;
    cnt_d     = cnt_q;
    is_load_d = is_load_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (lr_s) begin
          is_load_d = bus.isLoad;
          if (bus.isLoad && bus.isStore) begin
            // Illegal op: flag it but still deliver the token, with no strobes.
            err_d   = 1'b1;
            state_d = S_REQ;
          end else if (bus.isLoad || bus.isStore) begin
            state_d = S_ADDR;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_ADDR: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        // Acknowledge is checked first so it wins over a coincident timeout.
        if (ack_s) begin
          state_d = is_load_q ? S_DATA : S_REQ;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA:  state_d = S_REQ;
      S_REQ:   if (ra_s) state_d = S_RTZ;
      S_RTZ:   if (!lr_s && !ra_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    la_d         = (state_d == S_RTZ);
    rr_d         = (state_d == S_REQ);
    addr_latch_d = (state_d == S_ADDR);
    data_latch_d = (state_d == S_DATA);
    read_en_d    = (state_d == S_ACCESS) &&  is_load_d;
    write_en_d   = (state_d == S_ACCESS) && !is_load_d;
  end

  // All state, synchronizers and outputs; asynchronous reset clears everything.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      is_load_q    <= 1'b0;
      lr_sync_q    <= '0;
      ra_sync_q    <= '0;
      ack_sync_q   <= '0;
      la_q         <= 1'b0;
      rr_q         <= 1'b0;
      addr_latch_q <= 1'b0;
      read_en_q    <= 1'b0;
      write_en_q   <= 1'b0;
      data_latch_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_load_q    <= is_load_d;
      lr_sync_q    <= lr_sync_d;
      ra_sync_q    <= ra_sync_d;
      ack_sync_q   <= ack_sync_d;
      la_q         <= la_d;
      rr_q         <= rr_d;
      addr_latch_q <= addr_latch_d;
      read_en_q    <= read_en_d;
      write_en_q   <= write_en_d;
      data_latch_q <= data_latch_d;
      err_q        <= err_d;
    end
  end

  assign bus.la           = la_q;
  assign bus.rr           = rr_q;
  assign bus.memAddrLatch = addr_latch_q;
  assign bus.memReadEn    = read_en_q;
  assign bus.memWriteEn   = write_en_q;
  assign bus.memDataLatch = data_latch_q;
  assign bus.memErr       = err_q;

endmodule
`default_nettype wire
